mips_mc_controller: RTL
=======================

Name: mips_mc_controller

Overview:
- Main control unit for the multicycle MIPS core; sequences the shared-memory datapath (PC, IR, register file, ALU, unified instruction/data memory) through fetch, decode, execute, memory and writeback steps.
- Moore FSM plus ALU decoder.
- Adds a memory-ready handshake so the unified memory may take more than one cycle.
- Sits inside the core between the instruction register fields and the datapath enables.

Parameters:
- STATE_W, 4, width of the state register and the dbg_state port.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instruction opcode, instr[31:26].
- funct  in  6  instruction funct field, instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register select: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = Data.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC register enable.
- alucontrol  out  3  ALU operation.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- dbg_state  out  STATE_W  current state encoding.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12–15 are unreachable; if entered, go to FETCH.
- Reset low: state = FETCH immediately (asynchronous). While reset is low, memwrite, irwrite, regwrite, pcen and illegal are forced to 0; all other outputs take their FETCH values.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 100011 (lw) / 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXECUTE.
  - 000100 (beq) / 000101 (bne) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Any other op -> FETCH, with illegal=1 for this cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWR: iord=1, memwrite=1. memwrite stays high every cycle until mem_ready=1, then go to FETCH.
- MEMWB: regdst=0, memtoreg=1, regwrite=1; then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10; then ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1; then FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - Branch taken when beq and zero=1, or bne and zero=0.
  - Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00; then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1; then FETCH.
- JUMP: pcsrc=10, pcwrite=1; then FETCH.
- pcen = pcwrite | (branch_eq & zero) | (branch_ne & ~zero). It is combinational, from the current state and inputs.
- ALU decoder (alucontrol):
  - aluop 00 -> 010 (add).
  - aluop 01 -> 110 (sub).
  - aluop 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Any other funct -> 010; funct is never flagged illegal.
- Every output not listed for a state is 0 in that state, except alucontrol, which always follows the decoder.
- Latency without memory stalls (cycles from FETCH entry back to FETCH):
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; illegal op 2.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- op and funct are sampled combinationally. The IR is stable after FETCH, so no latching is needed here.

Test Plan:
- Reset: hold reset=0 for 3 cycles with mem_ready=1. Required: dbg_state=0; pcen=irwrite=memwrite=regwrite=0. Release: first edge with mem_ready=1 gives irwrite=pcen=1, then dbg_state=1.
- lw (op=100011) with mem_ready held 0 for 2 cycles in MEMRD. Required: dbg_state sequence 0,1,2,3,3,3,4,0; iord=1 in state 3; regwrite=1 and memtoreg=1 only in state 4.
- sw (op=101011) with mem_ready=1. Required: sequence 0,1,2,5,0; memwrite=1 for exactly one cycle with iord=1.
- R-type (op=000000) with funct = 100010, 100101 and 101010. Required: alucontrol in EXECUTE = 110, 001 and 111 respectively; regdst=1, regwrite=1 in ALUWB.
- beq with zero=1 gives pcen=1, pcsrc=01 in BRANCH; beq with zero=0 gives pcen=0. bne gives the opposite result in both cases.
- Illegal op=111111: required illegal=1 in DECODE, next state 0. Asserting reset=0 mid-MEMWR: memwrite drops the same cycle and dbg_state=0.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// rtl/mips_mc_controller_if.sv - instruction fields in, datapath controls out of the multicycle MIPS controller
interface mips_mc_controller_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic               pcen;
  logic [2:0]         alucontrol;
  logic               illegal;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal, dbg_state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal, dbg_state
  );
endinterface

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - Moore control FSM and ALU decoder for the multicycle MIPS core
// Memory states wait on mem_ready so the unified memory may take several cycles.
module mips_mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mc_controller_if.master bus
);
  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic       pcwrite, branch_eq, branch_ne, irwrite, memwrite, regwrite, illegal;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = FETCH;
    pcwrite         = 1'b0;
    branch_eq       = 1'b0;
    branch_ne       = 1'b0;
    irwrite         = 1'b0;
    memwrite        = 1'b0;
    regwrite        = 1'b0;
    illegal         = 1'b0;
    aluop           = 2'b00;
    bus.iord        = 1'b0;
    bus.regdst      = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.pcsrc       = 2'b00;
    case (state_q)
      FETCH: begin
        bus.alusrcb = 2'b01;
        irwrite     = bus.mem_ready;
        pcwrite     = bus.mem_ready;
        state_d     = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_RTYPE:       state_d = EXECUTE;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI:        state_d = ADDIEX;
          OP_J:           state_d = JUMP;
          default:        illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        state_d  = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite     = 1'b1;
      end
      MEMWR: begin
        bus.iord = 1'b1;
        memwrite = 1'b1;
        state_d  = bus.mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.regdst = 1'b1;
        regwrite   = 1'b1;
      end
      BRANCH: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b01;
        bus.pcsrc   = 2'b01;
        branch_eq   = (bus.op == OP_BEQ);
        branch_ne   = (bus.op == OP_BNE);
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Unknown funct codes fall back to add rather than raising illegal.
  always_comb begin
    bus.alucontrol = 3'b010;
    case (aluop)
      2'b01: bus.alucontrol = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          default:   bus.alucontrol = 3'b010;
        endcase
      end
      default: bus.alucontrol = 3'b010;
    endcase
  end

  // Write strobes are held off for as long as reset is low, not just until the next edge.
  assign bus.irwrite   = reset & irwrite;
  assign bus.memwrite  = reset & memwrite;
  assign bus.regwrite  = reset & regwrite;
  assign bus.illegal   = reset & illegal;
  assign bus.pcen      = reset & (pcwrite | (branch_eq & bus.zero) | (branch_ne & ~bus.zero));
  assign bus.dbg_state = state_q;
endmodule
